// File: rtl/inv_chain_arbiter_if.sv
// Requester-side bundle for the shared inverter-chain arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are held until the matching done pulse.
interface inv_chain_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_bit;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic               result;
    logic               mismatch;

    modport master (
        output req,
        output req_bit,
        input  gnt,
        input  done,
        input  result,
        input  mismatch
    );

    modport slave (
        input  req,
        input  req_bit,
        output gnt,
        output done,
        output result,
        output mismatch
    );
endinterface

// File: rtl/inv_chain_arbiter.sv
// Round-robin access controller sharing one inverting chain among NUM_REQ requesters.
// Latency: done pulses SETTLE_CYCLES+3 cycles after req is seen in IDLE.
// Backpressure: one operation at a time; others hold req until their done pulse.
module inv_chain_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int STAGES        = 3,
    parameter int ERR_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    inv_chain_arbiter_if.slave  bus,
    output logic [ERR_W-1:0]    err_cnt,
    output logic                busy,
    output logic                chain_in,
    input  logic                chain_out
);

    localparam int   PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic INV   = ((STAGES % 2) == 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic               drive;
    logic [7:0]         cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               result_q;
    logic               mismatch_q;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    int                 cand;
    logic               sample_miss;

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.mismatch = mismatch_q;

    // Search upward from the slot after the last winner, wrapping once.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req[PTR_W'(cand)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    assign sample_miss = chain_out ^ (drive ^ INV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= PTR_W'(NUM_REQ - 1);
            win        <= '0;
            drive      <= 1'b0;
            cnt        <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt    <= '0;
            busy       <= 1'b0;
            chain_in   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_q    <= NUM_REQ'(1) << win_idx;
                        win      <= win_idx;
                        drive    <= bus.req_bit[win_idx];
                        chain_in <= bus.req_bit[win_idx];
                        cnt      <= 8'(SETTLE_CYCLES - 1);
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    result_q   <= chain_out;
                    mismatch_q <= sample_miss;
                    if (sample_miss && (err_cnt != {ERR_W{1'b1}})) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    // Pulse lands in RESP, together with the freshly sampled result.
                    done_q <= gnt_q;
                    state  <= RESP;
                end
                RESP: begin
                    gnt_q <= '0;
                    busy  <= 1'b0;
                    ptr   <= win;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inv_chain_arbiter.md
Name: inv_chain_arbiter

Overview:
- Shares one hierarchical inverter chain between NUM_REQ requesters (e.g. level0 → level1 → level2, three inverting stages).
- Round-robin arbitration grants the chain to one requester at a time.
- The granted requester's test bit is driven into the chain, the block waits a programmable settle time, then samples the chain output.
- The sample is checked against the expected parity and returned to the requester with a done pulse.
- Serves as the access/sequencing controller in front of chain-based test structures.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- SETTLE_CYCLES, 3: cycles between driving chain_in and sampling chain_out; legal range 1..255.
- STAGES, 3: number of inverting stages in the chain. Expected output = drive bit XOR STAGES[0].
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NUM_REQ: per-requester request. Must be held until that requester's done pulse.
- req_bit, input, NUM_REQ: per-requester value to drive into the chain; sampled at grant.
- gnt, output, NUM_REQ: one-hot grant, held for the whole operation.
- done, output, NUM_REQ: one-hot, single-cycle completion pulse.
- result, output, 1: sampled chain_out; valid in the done cycle, holds afterwards.
- mismatch, output, 1: result != expected; valid in the done cycle, holds afterwards.
- err_cnt, output, ERR_W: saturating count of mismatches since reset.
- busy, output, 1: high in every state except IDLE.
- chain_in, output, 1: registered drive into the inverter chain.
- chain_out, input, 1: chain output, sampled in the SAMPLE state.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; gnt, done, result, mismatch, err_cnt, busy, chain_in = 0; RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, DRIVE, SETTLE, SAMPLE, RESP.
- IDLE:
  - If req != 0, pick the first set bit searching upward from pointer+1 (mod NUM_REQ).
  - Register gnt one-hot, latch drive = req_bit[winner], set chain_in = drive, load settle counter = SETTLE_CYCLES-1, go to DRIVE.
  - If req == 0, stay in IDLE with outputs unchanged.
- DRIVE: one cycle; chain_in stable. Go to SETTLE.
- SETTLE: decrement the counter each cycle. Exit to SAMPLE in the cycle the counter is 0.
- SAMPLE:
  - result = chain_out; mismatch = chain_out ^ (drive ^ STAGES[0]).
  - If mismatch and err_cnt is not all-ones, err_cnt += 1; at all-ones it holds.
  - Go to RESP.
- RESP:
  - done[winner] = 1 for exactly this cycle; gnt cleared at the end of the cycle; pointer = winner; go to IDLE.
  - No back-to-back bypass: IDLE is always visited for at least one cycle.
- Latency: req sampled high in IDLE at edge t:
  - gnt and chain_in valid from t+1;
  - sample taken at edge t+2+SETTLE_CYCLES;
  - done high in cycle t+3+SETTLE_CYCLES (t+6 with defaults).
- chain_in holds the last driven value between operations; it returns to 0 only on reset.
- A winner deasserting req mid-operation does not abort; done still pulses. A new req from the same requester is arbitrated normally.
- Simultaneous requests: exactly one gnt, round-robin fair; each active requester is served within NUM_REQ operations.
- req_bit changes after grant are ignored until the next grant.
- Reset mid-operation: immediate return to reset values, no done pulse, err_cnt cleared.
- Outputs gnt, done, busy, chain_in are registered; no combinational path from req to any output.

Test Plan:
- Single request, default params: req=4'b0001, req_bit=0, chain_out modelled as ~chain_in → gnt=0001 at t+1, chain_in=0, done=0001 at t+6, result=1, mismatch=0, err_cnt=0.
- All four requesting continuously, each req_bit=1 → grants in order 0,1,2,3,0 with done spacing 7 cycles each; never two gnt bits set; results all 0.
- Fault injection: chain_out forced to equal chain_in, 300 operations → mismatch=1 on each done, err_cnt saturates at 255 and holds.
- STAGES=2, chain_out = chain_in → mismatch=0. SETTLE_CYCLES=1 → done at t+4.
- Requester 2 drops req one cycle after grant, req_bit toggled mid-op → done[2] still pulses, result reflects the latched bit; next grant goes to 3.
- rst_n pulsed low during SETTLE → all outputs 0 asynchronously, no done. Post-reset request from 1 and 3 together → requester 1 granted first.
